// File: rtl/stall_pkg.sv
// Shared definitions for the L1-L9 stall request generators: FSM state
// encoding, default watermark constants and a width helper.
package stall_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_STALLED = 2'b01,
    ST_RESUME  = 2'b10
  } stall_state_e;

  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_HI_WM       = 12;
  localparam int unsigned DEF_LO_WM       = 4;
  localparam int unsigned DEF_MIN_RUN     = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  // Bits needed to hold a count from 0 to depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stall_occ_cnt.sv
// Saturating downstream-buffer occupancy counter with sticky
// overflow/underflow error. err_set lets the parent force the sticky flag.
module stall_occ_cnt
  import stall_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_pulse,
  input  logic                        rd_pulse,
  input  logic                        err_set,
  output logic [occ_width(DEPTH)-1:0] occ,
  output logic                        err
);

  localparam int unsigned OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  // Occupancy update; flush clears the count but keeps the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      err <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (flush) begin
        occ <= '0;
      end else if (wr_pulse && !rd_pulse) begin
        if (occ == FULL) err <= 1'b1;
        else             occ <= occ + 1'b1;
      end else if (rd_pulse && !wr_pulse) begin
        if (occ == '0) err <= 1'b1;
        else           occ <= occ - 1'b1;
      end
    end
  end

endmodule

// File: rtl/stall_req_gen_l1.sv
// L1 stall request generator: watches downstream buffer occupancy and
// issues one-cycle CLK_Dis / CLK_EN pulses to the layer clock gate with
// high/low watermark hysteresis and a minimum RESUME dwell.
// Optional: define STALL_TIMEOUT_EN to add a stall watchdog that forces
// RESUME after TIMEOUT_CYC stalled cycles and sets err.
module stall_req_gen_l1
  import stall_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned HI_WM       = DEF_HI_WM,
  parameter int unsigned LO_WM       = DEF_LO_WM,
  parameter int unsigned MIN_RUN     = DEF_MIN_RUN,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_pulse,
  input  logic                        rd_pulse,
  input  logic                        flush,
  output logic                        CLK_EN,
  output logic                        CLK_Dis,
  output logic                        stalled,
  output logic [occ_width(DEPTH)-1:0] occ,
  output logic                        err
);

  localparam int unsigned OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] HI_Q = OCC_W'(HI_WM);
  localparam logic [OCC_W-1:0] LO_Q = OCC_W'(LO_WM);
  localparam int unsigned RUN_W = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_RUN - 1);
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  stall_state_e   state;
  logic [RUN_W-1:0] run_cnt;
  logic           at_lo;
  logic           to_fire;

  assign at_lo = (occ <= LO_Q);

  stall_occ_cnt #(
    .DEPTH (DEPTH)
  ) u_occ (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_pulse (wr_pulse),
    .rd_pulse (rd_pulse),
    .err_set  (to_fire),
    .occ      (occ),
    .err      (err)
  );

`ifdef STALL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Watchdog expires only when the low watermark has not already released the stall.
  assign to_fire = (state == ST_STALLED) && !flush && !at_lo && (to_cnt == TO_LAST);

  // Watchdog counts stalled cycles and clears whenever STALLED is left.
  always_ff @(posedge clk) begin
    if (rst || flush || state != ST_STALLED || at_lo || to_fire) to_cnt <= '0;
    else                                                      to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_cfg;

  assign to_fire    = 1'b0;
  assign unused_cfg = ^TO_LAST;
`endif

  // Gate-control FSM with registered pulse and stalled outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      run_cnt <= '0;
      CLK_EN  <= 1'b0;
      CLK_Dis <= 1'b0;
      stalled <= 1'b0;
    end else begin
      CLK_EN  <= 1'b0;
      CLK_Dis <= 1'b0;
      if (flush) begin
        state   <= ST_RUN;
        run_cnt <= '0;
        stalled <= 1'b0;
        CLK_EN  <= (state == ST_STALLED);
      end else begin
        unique case (state)
          ST_RUN: begin
            if (occ >= HI_Q) begin
              state   <= ST_STALLED;
              CLK_Dis <= 1'b1;
              stalled <= 1'b1;
            end
          end
          ST_STALLED: begin
            if (at_lo || to_fire) begin
              state   <= ST_RESUME;
              run_cnt <= '0;
              CLK_EN  <= 1'b1;
              stalled <= 1'b0;
            end
          end
          ST_RESUME: begin
            if (run_cnt == RUN_LAST) state   <= ST_RUN;
            else                     run_cnt <= run_cnt + 1'b1;
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule
